// File: rtl/display_scan_if.sv
// -----------------------------------------------------------------------------
// display_scan_if
//   Bundles the control, data and scan signals of display_scan_driver.
//   master : the controller that drives enable/lzs_en/load/value_in and
//            observes the scan outputs (testbench or system logic).
//   slave  : the scan driver itself.
//
//   enable          1 = scan running, 0 = display dark
//   lzs_en          1 = suppress leading zero digits
//   load            1-cycle strobe, capture value_in
//   value_in[15:0]  new value, [15:12] most significant digit
//   an[3:0]         active-low anodes (0111,1011,1101,1110 or all off)
//   shown_value     value currently on display
//   digit_sel[1:0]  current slot index 0..3
//   frame_done      1-cycle pulse on the first cycle of each frame
//   update_pending  a loaded value is waiting for the frame boundary
// -----------------------------------------------------------------------------
interface display_scan_if;
  logic        enable;
  logic        lzs_en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  an;
  logic [15:0] shown_value;
  logic [1:0]  digit_sel;
  logic        frame_done;
  logic        update_pending;

  modport master (
    output enable, lzs_en, load, value_in,
    input  an, shown_value, digit_sel, frame_done, update_pending
  );

  modport slave (
    input  enable, lzs_en, load, value_in,
    output an, shown_value, digit_sel, frame_done, update_pending
  );
endinterface

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//   Active-low anode scan for a 4-digit 7-segment display. Each digit owns a
//   slot of PRESCALE clocks; the first BLANK_CYCLES clocks of every slot keep
//   all anodes off to avoid ghosting. New values are captured by a load strobe
//   and only take effect at a frame boundary (slot 3 -> slot 0), so a frame
//   never shows a mix of old and new digits. Optional leading-zero suppression
//   darkens zero digits above the most significant non-zero digit.
//
// Ports
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    display_scan_if.slave (see the interface for signal list)
//
// All outputs are registered. The anode register is loaded from the *next*
// counter/slot/value so that an always matches the digit_sel, cnt and
// shown_value that are current in the same cycle.
// -----------------------------------------------------------------------------
module display_scan_driver #(
  parameter int PRESCALE     = 50000,  // clocks per digit slot, >= BLANK_CYCLES+2
  parameter int BLANK_CYCLES = 500     // dark clocks at each slot start, may be 0
) (
  input  logic          clk,
  input  logic          rst_n,
  display_scan_if.slave bus
);

  localparam int              CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [3:0]      AN_OFF   = 4'b1111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    sel_q,     sel_d;
  logic [15:0]   shown_q,   shown_d;
  logic [15:0]   pend_q,    pend_d;
  logic          upd_q,     upd_d;
  logic          fd_q,      fd_d;
  logic [3:0]    an_q,      an_d;

  logic          slot_wrap;
  logic          boundary;
  logic          apply_now;
  logic          blanking;
  logic          suppressed;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a small flop with a defined reset value;
  // sequential state is always updated with non-blocking assignments so all
  // flops see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      shown_q <= 16'h0000;
      pend_q  <= 16'h0000;
      upd_q   <= 1'b0;
      fd_q    <= 1'b0;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      fd_q    <= fd_d;
      an_q    <= an_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: slot counter, digit index and the value update path
  // ---------------------------------------------------------------------------
  assign slot_wrap = (cnt_q == CNT_LAST);
  assign boundary  = bus.enable && slot_wrap && (sel_q == 2'd3);
  // While dark nothing is visible, so a waiting value may be applied at once
  // without tearing; otherwise only at the slot 3 -> slot 0 edge.
  assign apply_now = boundary || !bus.enable;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    shown_d = shown_q;
    pend_d  = pend_q;
    upd_d   = upd_q;
    fd_d    = boundary;

    if (!bus.enable) begin
      cnt_d = '0;
      sel_d = 2'd0;
    end else if (slot_wrap) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Last load wins: a new strobe always overwrites the pending value.
    if (bus.load) begin
      pend_d = bus.value_in;
    end

    if (apply_now) begin
      // A load coinciding with the boundary bypasses the pending register.
      if (bus.load) begin
        shown_d = bus.value_in;
      end else if (upd_q) begin
        shown_d = pend_q;
      end
      upd_d = 1'b0;
    end else if (bus.load) begin
      upd_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Anode decode, evaluated on next-state values and then registered
  // ---------------------------------------------------------------------------
  assign blanking = (int'(cnt_d) < BLANK_CYCLES);

  // Slot 0 is never suppressed so a value of zero still shows a single "0".
  always_comb begin
    suppressed = 1'b0;
    if (bus.lzs_en) begin
      unique case (sel_d)
        2'd3:    suppressed = (shown_d[15:12] == 4'h0);
        2'd2:    suppressed = (shown_d[15:8]  == 8'h00);
        2'd1:    suppressed = (shown_d[15:4]  == 12'h000);
        default: suppressed = 1'b0;
      endcase
    end
  end

  always_comb begin
    an_d = AN_OFF;
    if (bus.enable && !blanking && !suppressed) begin
      unique case (sel_d)
        2'd0:    an_d = 4'b0111;  // digit [3:0]
        2'd1:    an_d = 4'b1011;  // digit [7:4]
        2'd2:    an_d = 4'b1101;  // digit [11:8]
        default: an_d = 4'b1110;  // digit [15:12]
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.an             = an_q;
  assign bus.shown_value    = shown_q;
  assign bus.digit_sel      = sel_q;
  assign bus.frame_done     = fd_q;
  assign bus.update_pending = upd_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
//   Self-checking bench for display_scan_driver with PRESCALE=8, BLANK_CYCLES=2.
//   The reference model tracks the position inside a 4*PRESCALE frame as a
//   single integer and derives slot, blanking and suppression arithmetically.
//   Inputs change just after a falling edge, outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

  localparam int P = 8;
  localparam int B = 2;
  localparam int F = 4 * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_if bus ();

  display_scan_driver #(
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic en_drv  = 1'b0;
  logic lzs_drv = 1'b0;

  // Reference model state (what the outputs should be after the last edge)
  int          m_t;
  logic [15:0] m_shown;
  logic [15:0] m_pv;
  logic        m_upd;
  logic        m_fd;
  logic        m_en;
  logic        m_lzs;

  task automatic model_reset();
    m_t = 0; m_shown = 16'h0; m_pv = 16'h0; m_upd = 1'b0;
    m_fd = 1'b0; m_en = 1'b0; m_lzs = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] val);
    logic bnd;
    logic apply;
    bnd = en_drv && (m_t == F - 1);
    m_t = en_drv ? (m_t + 1) % F : 0;
    m_fd = bnd;
    apply = bnd || !en_drv;
    if (apply) begin
      if (ld) m_shown = val;
      else if (m_upd) m_shown = m_pv;
      m_upd = 1'b0;
    end else if (ld) begin
      m_pv = val;
      m_upd = 1'b1;
    end
    m_en = en_drv;
    m_lzs = lzs_drv;
  endtask

  function automatic logic [3:0] exp_an();
    int slot;
    int pos;
    logic [3:0] onehot;
    slot = m_t / P;
    pos  = m_t % P;
    if (!m_en || pos < B) return 4'b1111;
    if (m_lzs) begin
      if (slot == 3 && m_shown[15:12] == 4'h0) return 4'b1111;
      if (slot == 2 && m_shown[15:8] == 8'h0) return 4'b1111;
      if (slot == 1 && m_shown[15:4] == 12'h0) return 4'b1111;
    end
    onehot = 4'b1000 >> slot;
    return ~onehot;
  endfunction

  function automatic logic [1:0] exp_sel();
    return 2'(m_t / P);
  endfunction

  // One clock: drive inputs, advance the model, wait to the sampling edge.
  task automatic tick(input logic ld, input logic [15:0] val);
    bus.enable   = en_drv;
    bus.lzs_en   = lzs_drv;
    bus.load     = ld;
    bus.value_in = val;
    model_edge(ld, val);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic advance_to(input int t);
    for (int i = 0; i < 2 * F && m_t != t; i++) tick(1'b0, 16'h0);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < F + 1 && !m_fd; i++) tick(1'b0, 16'h0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_cmp++;
    if (bus.an !== 4'b1111) begin
      n_bad++; $display("FAIL reset_an got %b exp 1111", bus.an);
    end
    n_cmp++;
    if (bus.shown_value !== 16'h0 || bus.digit_sel !== 2'd0) begin
      n_bad++; $display("FAIL reset_value got %h/%0d exp 0000/0", bus.shown_value, bus.digit_sel);
    end
    n_cmp++;
    if (bus.frame_done !== 1'b0 || bus.update_pending !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got fd=%b up=%b exp 0/0", bus.frame_done, bus.update_pending);
    end
  endtask

  task automatic test_scan();
    int pulses;
    pulses = 0;
    en_drv = 1'b1; lzs_drv = 1'b0;
    for (int i = 0; i < 2 * F; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++;
      if (bus.an !== exp_an() || bus.digit_sel !== exp_sel()) begin
        n_bad++;
        $display("FAIL scan t=%0d got an=%b sel=%0d exp an=%b sel=%0d",
                 m_t, bus.an, bus.digit_sel, exp_an(), exp_sel());
      end
      n_cmp++;
      if (bus.frame_done !== m_fd) begin
        n_bad++; $display("FAIL scan_frame_done t=%0d got %b exp %b", m_t, bus.frame_done, m_fd);
      end
      if (bus.frame_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++; $display("FAIL scan_pulse_count got %0d exp 2", pulses);
    end
  endtask

  task automatic test_deferred_update();
    advance_to(P + 3);
    tick(1'b1, 16'h1234);
    n_cmp++;
    if (bus.update_pending !== 1'b1 || bus.shown_value !== 16'h0000) begin
      n_bad++; $display("FAIL defer_capture got up=%b shown=%h exp 1/0000", bus.update_pending, bus.shown_value);
    end
    for (int i = 0; i < F && !m_fd; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++;
      if (bus.shown_value !== m_shown || bus.update_pending !== m_upd) begin
        n_bad++; $display("FAIL defer_hold t=%0d got %h/%b exp %h/%b",
                          m_t, bus.shown_value, bus.update_pending, m_shown, m_upd);
      end
    end
    n_cmp++;
    if (bus.shown_value !== 16'h1234 || bus.frame_done !== 1'b1 || bus.update_pending !== 1'b0) begin
      n_bad++; $display("FAIL defer_apply got shown=%h fd=%b up=%b exp 1234/1/0",
                        bus.shown_value, bus.frame_done, bus.update_pending);
    end
  endtask

  task automatic test_last_wins();
    advance_to(2);
    tick(1'b1, 16'hAAAA);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0);
    tick(1'b1, 16'h0BCD);
    for (int i = 0; i < F && !m_fd; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++;
      if (bus.shown_value === 16'hAAAA) begin
        n_bad++; $display("FAIL last_wins_stale got %h exp not AAAA", bus.shown_value);
      end
    end
    n_cmp++;
    if (bus.shown_value !== 16'h0BCD) begin
      n_bad++; $display("FAIL last_wins got %h exp 0bcd", bus.shown_value);
    end
  endtask

  task automatic test_lzs();
    logic [15:0] vals [5];
    int lit [4];
    vals[0] = 16'h0042; vals[1] = 16'h0000; vals[2] = 16'h0007;
    vals[3] = 16'($urandom_range(0, 16'h0FFF)); vals[4] = 16'($urandom);
    lzs_drv = 1'b1;
    foreach (vals[k]) begin
      advance_to(5);
      tick(1'b1, vals[k]);
      wait_frame();
      for (int s = 0; s < 4; s++) lit[s] = 0;
      for (int i = 0; i < F; i++) begin
        n_cmp++;
        if (bus.an !== exp_an() || $countones(~bus.an) > 1) begin
          n_bad++; $display("FAIL lzs v=%h t=%0d got an=%b exp %b", vals[k], m_t, bus.an, exp_an());
        end
        if (bus.an !== 4'b1111) lit[m_t / P]++;
        tick(1'b0, 16'h0);
      end
      if (k == 0) begin
        n_cmp++;
        if (lit[0] != P - B || lit[1] != P - B || lit[2] != 0 || lit[3] != 0) begin
          n_bad++; $display("FAIL lzs_0042 lit=%0d,%0d,%0d,%0d exp 6,6,0,0", lit[0], lit[1], lit[2], lit[3]);
        end
      end else if (k == 1) begin
        n_cmp++;
        if (lit[0] != P - B || lit[1] + lit[2] + lit[3] != 0) begin
          n_bad++; $display("FAIL lzs_zero lit=%0d,%0d,%0d,%0d exp 6,0,0,0", lit[0], lit[1], lit[2], lit[3]);
        end
      end
    end
    lzs_drv = 1'b0;
  endtask

  task automatic test_boundary_load();
    advance_to(F - 1);
    tick(1'b1, 16'h5678);
    n_cmp++;
    if (bus.shown_value !== 16'h5678 || bus.update_pending !== 1'b0 || bus.frame_done !== 1'b1) begin
      n_bad++; $display("FAIL boundary_load got %h up=%b fd=%b exp 5678/0/1",
                        bus.shown_value, bus.update_pending, bus.frame_done);
    end
  endtask

  task automatic test_enable();
    logic [15:0] v;
    advance_to(2 * P + 4);
    tick(1'b1, 16'h9ABC);
    en_drv = 1'b0;
    tick(1'b0, 16'h0);
    n_cmp++;
    if (bus.an !== 4'b1111 || bus.digit_sel !== 2'd0 || bus.frame_done !== 1'b0) begin
      n_bad++; $display("FAIL disable got an=%b sel=%0d fd=%b exp 1111/0/0", bus.an, bus.digit_sel, bus.frame_done);
    end
    n_cmp++;
    if (bus.shown_value !== 16'h9ABC || bus.update_pending !== 1'b0) begin
      n_bad++; $display("FAIL disable_apply got %h up=%b exp 9abc/0", bus.shown_value, bus.update_pending);
    end
    v = 16'($urandom);
    tick(1'b1, v);
    tick(1'b0, 16'h0);
    n_cmp++;
    if (bus.shown_value !== m_shown || bus.an !== 4'b1111) begin
      n_bad++; $display("FAIL disable_load got %h an=%b exp %h/1111", bus.shown_value, bus.an, m_shown);
    end
    en_drv = 1'b1;
    for (int i = 0; i < P + 2; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++;
      if (bus.an !== exp_an() || bus.digit_sel !== exp_sel()) begin
        n_bad++; $display("FAIL reenable t=%0d got an=%b sel=%0d exp %b/%0d",
                          m_t, bus.an, bus.digit_sel, exp_an(), exp_sel());
      end
    end
  endtask

  task automatic test_random();
    logic ld;
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) en_drv = ~en_drv;
      if ($urandom_range(0, 49) == 0) lzs_drv = ~lzs_drv;
      ld = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      tick(ld, v);
      n_cmp++;
      if (bus.an !== exp_an() || bus.digit_sel !== exp_sel() || bus.frame_done !== m_fd ||
          bus.shown_value !== m_shown || bus.update_pending !== m_upd) begin
        n_bad++;
        $display("FAIL random i=%0d got an=%b sel=%0d fd=%b sv=%h up=%b exp %b/%0d/%b/%h/%b",
                 i, bus.an, bus.digit_sel, bus.frame_done, bus.shown_value, bus.update_pending,
                 exp_an(), exp_sel(), m_fd, m_shown, m_upd);
      end
    end
    en_drv = 1'b1; lzs_drv = 1'b0;
  endtask

  task automatic test_reset_mid_slot();
    advance_to(P + 4);
    tick(1'b1, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.an !== 4'b1111 || bus.shown_value !== 16'h0 || bus.digit_sel !== 2'd0 ||
        bus.update_pending !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got an=%b sv=%h sel=%0d up=%b exp 1111/0000/0/0",
                        bus.an, bus.shown_value, bus.digit_sel, bus.update_pending);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < F + 2; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++;
      if (bus.shown_value !== 16'h0 || bus.an !== exp_an()) begin
        n_bad++; $display("FAIL reset_discard t=%0d got sv=%h an=%b exp 0000/%b",
                          m_t, bus.shown_value, bus.an, exp_an());
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bus.enable = 1'b0; bus.lzs_en = 1'b0; bus.load = 1'b0; bus.value_in = 16'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_scan();
    test_deferred_update();
    test_last_wins();
    test_lzs();
    test_boundary_load();
    test_enable();
    test_random();
    test_reset_mid_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
